// File: rtl/up_down_counter_255_if.sv
// rtl/up_down_counter_255_if.sv - host strobe/address bundle for the bouncing counter
interface up_down_counter_255_if;
  logic ncs;
  logic nrd;
  logic nwr;
  logic a0;
  logic a1;
  logic start;

  modport master (output ncs, nrd, nwr, a0, a1, start);
  modport slave  (input  ncs, nrd, nwr, a0, a1, start);
endinterface

// File: rtl/up_down_counter_255.sv
// rtl/up_down_counter_255.sv - bus-programmable counter bouncing between LLR and ULR for CCR cycles
module up_down_counter_255 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  up_down_counter_255_if.slave bus,
  inout  wire  [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     count,
  output logic                 err,
  output logic                 ec,
  output logic                 dir
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
  logic [WIDTH-1:0] count_q, count_d, cyc_q, cyc_d;
  logic             dir_q, dir_d, err_q, err_d, ec_q, ec_d;

  logic [1:0]       addr;
  logic             wr_en, rd_en, start_acc, cfg_ok;
  logic [WIDTH-1:0] count_inc, count_dec, cyc_inc, rd_data;

  assign addr      = {bus.a1, bus.a0};
  assign wr_en     = !bus.ncs && !bus.nwr && (state_q != RUN);
  assign rd_en     = !bus.ncs && !bus.nrd && bus.nwr;
  assign start_acc = bus.start && !bus.ncs && bus.nwr;
  assign cfg_ok    = (llr_q < ulr_q) && (llr_q <= plr_q) && (plr_q <= ulr_q) && (ccr_q != '0);
  assign count_inc = count_q + WIDTH'(1);
  assign count_dec = count_q - WIDTH'(1);
  assign cyc_inc   = cyc_q + WIDTH'(1);

  always_comb begin
    rd_data = plr_q;
    case (addr)
      2'b00:   rd_data = plr_q;
      2'b01:   rd_data = ulr_q;
      2'b10:   rd_data = llr_q;
      default: rd_data = ccr_q;
    endcase
  end

  // Simultaneous nrd/nwr low is a write, so the bus is left to the host.
  assign din = rd_en ? rd_data : {WIDTH{1'bz}};

  always_comb begin
    state_d = state_q;
    plr_d   = plr_q;
    ulr_d   = ulr_q;
    llr_d   = llr_q;
    ccr_d   = ccr_q;
    count_d = count_q;
    cyc_d   = cyc_q;
    dir_d   = dir_q;
    err_d   = err_q;
    ec_d    = ec_q;

    if (wr_en) begin
      case (addr)
        2'b00:   plr_d = din;
        2'b01:   ulr_d = din;
        2'b10:   llr_d = din;
        default: ccr_d = din;
      endcase
    end

    if (start_acc) begin
      ec_d = 1'b0;
      if (cfg_ok) begin
        err_d   = 1'b0;
        count_d = plr_q;
        cyc_d   = '0;
        state_d = RUN;
        dir_d   = (plr_q != ulr_q);
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == RUN) begin
      if (dir_q) begin
        count_d = count_inc;
        if (count_inc == ulr_q) dir_d = 1'b0;
      end else begin
        count_d = count_dec;
        // Reaching LLR on the way down closes one full up/down cycle.
        if (count_dec == llr_q) begin
          cyc_d = cyc_inc;
          if (cyc_inc == ccr_q) begin
            state_d = DONE;
            ec_d    = 1'b1;
          end else begin
            dir_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      plr_q   <= '0;
      ulr_q   <= '0;
      llr_q   <= '0;
      ccr_q   <= '0;
      count_q <= '0;
      cyc_q   <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      plr_q   <= plr_d;
      ulr_q   <= ulr_d;
      llr_q   <= llr_d;
      ccr_q   <= ccr_d;
      count_q <= count_d;
      cyc_q   <= cyc_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;
  assign ec    = ec_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_up_down_counter_255.sv
// tb/tb_up_down_counter_255.sv - directed self-checking bench for up_down_counter_255
module tb_up_down_counter_255;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic       err, ec, dir;
  logic       tb_oe;
  logic [7:0] tb_drv;
  wire  [7:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  int basic_seq [36] = '{10, 11, 12, 13, 14, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5,
                         6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                         14, 13, 12, 11, 10, 9, 8, 7, 6, 5};
  int bound_seq [10] = '{5, 4, 3, 2, 3, 4, 5, 4, 3, 2};

  up_down_counter_255_if bus_if ();

  up_down_counter_255 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .din   (din),
    .count (count),
    .err   (err),
    .ec    (ec),
    .dir   (dir)
  );

  assign din = tb_oe ? tb_drv : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d, input logic rd_too);
    @(negedge clk);
    {bus_if.a1, bus_if.a0} = a;
    bus_if.ncs = 1'b0;
    bus_if.nwr = 1'b0;
    bus_if.nrd = ~rd_too;
    tb_drv = d;
    tb_oe  = 1'b1;
    @(posedge clk);
    #1;
    tb_oe = 1'b0;
    bus_if.ncs = 1'b1;
    bus_if.nwr = 1'b1;
    bus_if.nrd = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    {bus_if.a1, bus_if.a0} = a;
    bus_if.ncs = 1'b0;
    bus_if.nrd = 1'b0;
    bus_if.nwr = 1'b1;
    #2;
    d = din;
    bus_if.ncs = 1'b1;
    bus_if.nrd = 1'b1;
  endtask

  task automatic config_regs(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                             input logic [7:0] c);
    write_reg(2'b00, p, 1'b0);
    write_reg(2'b01, u, 1'b0);
    write_reg(2'b10, l, 1'b0);
    write_reg(2'b11, c, 1'b0);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.ncs   = 1'b0;
    bus_if.nwr   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.ncs   = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_regs_zero(input string tag);
    logic [7:0] rv;
    for (int a = 0; a < 4; a++) begin
      read_reg(a[1:0], rv);
      check(tag, rv, 0);
    end
  endtask

  initial begin
    logic [7:0] rv;
    reset = 1'b0;
    tb_oe = 1'b0;
    tb_drv = '0;
    bus_if.ncs = 1'b1;
    bus_if.nrd = 1'b1;
    bus_if.nwr = 1'b1;
    bus_if.a0 = 1'b0;
    bus_if.a1 = 1'b0;
    bus_if.start = 1'b0;

    #12;
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    check("rst_ec", ec, 0);
    check("rst_dir", dir, 1);
    check_regs_zero("rst_regs");
    @(negedge clk);
    reset = 1'b1;

    // Register write/read-back; CCR written with nrd also low
    write_reg(2'b00, 8'd10, 1'b0);
    write_reg(2'b01, 8'd15, 1'b0);
    write_reg(2'b10, 8'd5, 1'b0);
    write_reg(2'b11, 8'd2, 1'b1);
    read_reg(2'b00, rv); check("rb_plr", rv, 10);
    read_reg(2'b01, rv); check("rb_ulr", rv, 15);
    read_reg(2'b10, rv); check("rb_llr", rv, 5);
    read_reg(2'b11, rv); check("rb_ccr", rv, 2);

    // With nrd high the DUT must leave the bus to the host's value
    bus_if.ncs = 1'b0;
    tb_drv = 8'hA5;
    tb_oe  = 1'b1;
    #2;
    check("bus_hiz", din, 8'hA5);
    tb_oe = 1'b0;
    bus_if.ncs = 1'b1;

    // Basic 10/15/5/2 bounce
    do_start();
    check("basic_count", count, basic_seq[0]);
    check("basic_dir0", dir, 1);
    for (int k = 1; k < 36; k++) begin
      run_edges(1);
      check("basic_count", count, basic_seq[k]);
      if (k == 4)  check("basic_dir_up", dir, 1);
      if (k == 5)  check("basic_dir_down", dir, 0);
      if (k == 34) check("basic_ec_early", ec, 0);
      if (k == 35) check("basic_ec", ec, 1);
    end
    run_edges(3);
    check("done_hold_count", count, 5);
    check("done_hold_ec", ec, 1);
    check("done_hold_dir", dir, 0);

    // Invalid configurations from a clean reset
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    config_regs(8'd15, 8'd10, 8'd5, 8'd2);
    do_start();
    check("inv_a_err", err, 1);
    check("inv_a_ec", ec, 0);
    run_edges(3);
    check("inv_a_count", count, 0);
    config_regs(8'd5, 8'd5, 8'd5, 8'd2);
    do_start();
    run_edges(3);
    check("inv_b_err", err, 1);
    check("inv_b_count", count, 0);
    config_regs(8'd10, 8'd15, 8'd5, 8'd0);
    do_start();
    run_edges(3);
    check("inv_c_err", err, 1);
    check("inv_c_count", count, 0);

    // Boundary start at ULR
    config_regs(8'd5, 8'd5, 8'd2, 8'd2);
    do_start();
    check("bnd_err", err, 0);
    check("bnd_dir0", dir, 0);
    check("bnd_count", count, bound_seq[0]);
    for (int k = 1; k < 10; k++) begin
      run_edges(1);
      check("bnd_count", count, bound_seq[k]);
      if (k == 8) check("bnd_ec_early", ec, 0);
      if (k == 9) check("bnd_ec", ec, 1);
    end

    // Restart at 8 edges, then again after one full cycle so the cycle count must clear
    config_regs(8'd10, 8'd15, 8'd5, 8'd2);
    do_start();
    run_edges(7);
    check("rs_pre", count, 13);
    do_start();
    check("rs_reload", count, 10);
    run_edges(19);
    check("rs_mid", count, 9);
    do_start();
    check("rs_reload2", count, 10);
    run_edges(34);
    check("rs_count34", count, 6);
    check("rs_ec34", ec, 0);
    run_edges(1);
    check("rs_count35", count, 5);
    check("rs_ec35", ec, 1);

    // Write during RUN is ignored; ncs high blocks start but not counting
    do_start();
    run_edges(2);
    write_reg(2'b00, 8'd20, 1'b0);
    check("wrun_count", count, 13);
    read_reg(2'b00, rv);
    check("wrun_plr", rv, 10);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.ncs   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("ncs_start_ign", count, 14);
    run_edges(1);
    check("ncs_count", count, 15);
    check("ncs_dir", dir, 0);

    // Asynchronous reset mid-run
    run_edges(2);
    #3;
    reset = 1'b0;
    #1;
    check("mrst_count", count, 0);
    check("mrst_err", err, 0);
    check("mrst_ec", ec, 0);
    check("mrst_dir", dir, 1);
    check_regs_zero("mrst_regs");
    @(negedge clk);
    reset = 1'b1;
    run_edges(2);
    check("mrst_idle", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
